rx_unit_receiver: RTL

Receive-side counterpart of the transmit unit. It deserializes frames from the serial line (start, 8 data bits LSB-first, parity, stop), checks parity and framing, and buffers each good frame as a 9-bit entry {parity_err, data[7:0]} in an internal FIFO. The external system drains the FIFO with a read handshake. Rx_ready tells the transmit side the FIFO can accept a frame.

---
 rtl/rx_unit_receiver.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/rx_unit_receiver.sv
// rtl/rx_unit_receiver.sv - serial frame receiver with parity/framing check and read FIFO
//
// Deserializes start + 8 data bits (LSB first) + parity + stop from data_in,
// one bit per baud_clk edge, and queues each frame whose stop bit is good as
// {parity_err, data[7:0]}.
//
// Ports:
//   baud_clk    bit-rate clock, one serial bit sampled per rising edge
//   rst         synchronous active-high reset
//   data_in     serial line, idles high
//   parity_sel  0 = even, 1 = odd parity; stable for the whole frame
//   rd_en       pop request; ignored while the FIFO is empty
//   Rx_ready    FIFO can accept another frame
//   data_out    data byte of the most recently popped entry
//   parity_err  parity flag of the most recently popped entry
//   data_valid  one-cycle pulse when data_out/parity_err were updated
//   RxFE/RxFF   FIFO empty / full
//   frame_err   one-cycle pulse: stop bit sampled low
//   overrun     one-cycle pulse: good frame dropped, FIFO was full
module rx_unit_receiver #(
  parameter int FIFO_WIDTH_R = 9,
  parameter int FIFO_DEPTH_R = 16
) (
  input  logic       baud_clk,
  input  logic       rst,
  input  logic       data_in,
  input  logic       parity_sel,
  input  logic       rd_en,
  output logic       Rx_ready,
  output logic [7:0] data_out,
  output logic       parity_err,
  output logic       data_valid,
  output logic       RxFE,
  output logic       RxFF,
  output logic       frame_err,
  output logic       overrun
);

  localparam int PW = $clog2(FIFO_DEPTH_R);
  localparam int CW = $clog2(FIFO_DEPTH_R + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH_R);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_DATA      = 3'd1;
  localparam logic [2:0] S_PARITY    = 3'd2;
  localparam logic [2:0] S_STOP      = 3'd3;
  localparam logic [2:0] S_WAIT_IDLE = 3'd4;

  logic [2:0]              r_state;
  logic [2:0]              r_bit_cnt;
  logic [7:0]              r_shift;
  logic                    r_par_bit;
  logic [FIFO_WIDTH_R-1:0] r_mem [FIFO_DEPTH_R];
  logic [PW-1:0]           r_wr_ptr;
  logic [PW-1:0]           r_rd_ptr;
  logic [CW-1:0]           r_count;

  logic                    w_good_stop;
  logic                    w_has_space;
  logic                    w_wr;
  logic                    w_rd;
  logic                    w_par_err;
  logic [FIFO_WIDTH_R-1:0] w_entry;

  // Received parity differs from (^data ^ parity_sel) -> flag the entry.
  assign w_par_err   = r_par_bit ^ (^r_shift) ^ parity_sel;
  assign w_entry     = {w_par_err, r_shift};

  // Space is judged on the count before this edge, so a same-edge pop
  // never makes room for the incoming frame.
  assign w_good_stop = (r_state == S_STOP) && data_in;
  assign w_has_space = (r_count < DEPTH_C);
  assign w_wr        = w_good_stop && w_has_space;
  assign w_rd        = rd_en && (r_count != '0);

  assign RxFE     = (r_count == '0);
  assign RxFF     = (r_count == DEPTH_C);
  assign Rx_ready = ~RxFF;

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_bit_cnt <= '0;
      r_shift   <= '0;
      r_par_bit <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (!data_in) begin
            r_state   <= S_DATA;
            r_bit_cnt <= '0;
          end
        end
        S_DATA: begin
          r_shift[r_bit_cnt] <= data_in;
          r_bit_cnt          <= r_bit_cnt + 3'd1;
          if (r_bit_cnt == 3'd7) r_state <= S_PARITY;
        end
        S_PARITY: begin
          r_par_bit <= data_in;
          r_state   <= S_STOP;
        end
        S_STOP: begin
          if (data_in) begin
            r_state <= S_IDLE;
          end else begin
            frame_err <= 1'b1;
            r_state   <= S_WAIT_IDLE;
          end
        end
        // Hold here while the line stays low so a stuck-low line cannot
        // be mistaken for a string of start bits.
        S_WAIT_IDLE: begin
          if (data_in) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge baud_clk) begin
    if (w_wr && !rst) r_mem[r_wr_ptr] <= w_entry;
  end

  always_ff @(posedge baud_clk) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      data_out   <= 8'd0;
      parity_err <= 1'b0;
      data_valid <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      data_valid <= w_rd;
      overrun    <= w_good_stop && !w_has_space;
      if (w_wr) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_rd) begin
        r_rd_ptr   <= r_rd_ptr + PW'(1);
        data_out   <= r_mem[r_rd_ptr][7:0];
        parity_err <= r_mem[r_rd_ptr][8];
      end
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule
